// File: rtl/jt12_ss_ctrl.sv
// jt12_ss_ctrl: save-state transfer controller for the JT12 auto save-state chain.
// Save: freeze the chain, snapshot auto_ss_out, stream it out LSB word first.
// Load: collect words into the shadow register, then commit with one auto_ss_wr pulse.
module jt12_ss_ctrl #(
    parameter int SS_WIDTH = 120
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                ss_save,
    input  logic                ss_load,
    input  logic [SS_WIDTH-1:0] auto_ss_out,
    output logic [SS_WIDTH-1:0] auto_ss_in,
    output logic                auto_ss_wr,
    output logic                hold,
    output logic [15:0]         wr_data,
    output logic                wr_valid,
    input  logic                wr_ready,
    input  logic [15:0]         rd_data,
    input  logic                rd_valid,
    output logic                rd_ready,
    output logic                busy,
    output logic                done
);

    localparam int WORDS = (SS_WIDTH + 15) / 16;
    localparam int TW    = WORDS * 16;
    localparam int K_W   = (WORDS > 1) ? $clog2(WORDS) : 1;
    localparam int IW    = $clog2(TW);

    localparam logic [K_W-1:0] K_LAST   = K_W'(WORDS - 1);
    localparam logic [K_W-1:0] K_ONE    = K_W'(1);
    localparam logic [TW-1:0]  ONE_TW   = TW'(1);
    // Ones over the real save-state bits, zeros over the padding of the last word.
    localparam logic [TW-1:0]  PAD_MASK = (ONE_TW << SS_WIDTH) - ONE_TW;

    typedef enum logic [2:0] {
        IDLE,
        SNAP,
        SEND,
        RECV,
        COMMIT,
        DONE
    } state_t;

    state_t         state_q;
    logic [K_W-1:0] k_q;
    // Shadow is padded to a whole number of words; padding bits are kept at zero
    // so the top word of a save carries zeros above SS_WIDTH-1.
    logic [TW-1:0]  shadow_q;
    logic [TW-1:0]  shadow_d;
    logic [IW-1:0]  base;
    logic           hold_q;
    logic           wr_valid_q;
    logic           rd_ready_q;
    logic           ss_wr_q;
    logic           done_q;

    // Bit offset of the current word inside the shadow.
    assign base = IW'({k_q, 4'b0000});

    // Shadow with the incoming load word merged at the current word slot.
    always_comb begin
        // NOTE: start from a full default so every path assigns shadow_d; a missing
        // default in always_comb would infer a latch.
        shadow_d             = shadow_q;
        shadow_d[base +: 16] = rd_data;
        shadow_d             = shadow_d & PAD_MASK;
    end

    // Transfer FSM; control outputs are registered alongside the state.
    always_ff @(posedge clk) begin
        // NOTE: state is updated with non-blocking assignments so every register
        // sees the pre-edge values of the others, exactly as the hardware does.
        if (rst) begin
            state_q    <= IDLE;
            k_q        <= '0;
            // NOTE: the shadow is wide but still reset, so auto_ss_in is zero after
            // reset and no half-loaded image survives an abandoned transfer.
            shadow_q   <= '0;
            hold_q     <= 1'b0;
            wr_valid_q <= 1'b0;
            rd_ready_q <= 1'b0;
            ss_wr_q    <= 1'b0;
            done_q     <= 1'b0;
        end else begin
            ss_wr_q <= 1'b0;
            done_q  <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (ss_save) begin
                        state_q <= SNAP;
                        hold_q  <= 1'b1;
                    end else if (ss_load) begin
                        state_q    <= RECV;
                        k_q        <= '0;
                        hold_q     <= 1'b1;
                        rd_ready_q <= 1'b1;
                    end
                end
                SNAP: begin
                    shadow_q   <= TW'(auto_ss_out);
                    k_q        <= '0;
                    state_q    <= SEND;
                    wr_valid_q <= 1'b1;
                end
                SEND: begin
                    if (wr_valid_q && wr_ready) begin
                        if (k_q == K_LAST) begin
                            state_q    <= DONE;
                            wr_valid_q <= 1'b0;
                            done_q     <= 1'b1;
                        end else begin
                            k_q <= k_q + K_ONE;
                        end
                    end
                end
                RECV: begin
                    if (rd_valid && rd_ready_q) begin
                        shadow_q <= shadow_d;
                        if (k_q == K_LAST) begin
                            state_q    <= COMMIT;
                            rd_ready_q <= 1'b0;
                            ss_wr_q    <= 1'b1;
                        end else begin
                            k_q <= k_q + K_ONE;
                        end
                    end
                end
                COMMIT: begin
                    state_q <= DONE;
                    done_q  <= 1'b1;
                end
                DONE: begin
                    state_q <= IDLE;
                    hold_q  <= 1'b0;
                end
                default: begin
                    state_q    <= IDLE;
                    hold_q     <= 1'b0;
                    wr_valid_q <= 1'b0;
                    rd_ready_q <= 1'b0;
                end
            endcase
        end
    end

    // The outgoing word is a mux of registered state only; it is held while stalled.
    assign wr_data    = wr_valid_q ? shadow_q[base +: 16] : 16'h0000;
    assign auto_ss_in = shadow_q[SS_WIDTH-1:0];
    assign auto_ss_wr = ss_wr_q;
    assign hold       = hold_q;
    assign busy       = hold_q;
    assign wr_valid   = wr_valid_q;
    assign rd_ready   = rd_ready_q;
    assign done       = done_q;

endmodule
